decoder_2to4: RTL and testbench
===============================

// Module: decoder_2to4
// PURPOSE
//  - Registered 2-to-4 one-hot decoder with enable.
//  - Converts a 2-bit binary select (data_in) into a 4-bit one-hot word (y_out), captured on clk.
//  - Leaf block used wherever a small binary index must drive per-line selects
//    (chip selects, register-bank write enables).
// PARAMETERS
//  - IN_W        2  select width; output width OUT_W = 2**IN_W (default 4); legal range 1..4
//  - ACTIVE_LOW  0  0: selected line = 1, others 0; 1: all outputs inverted (selected line = 0)
// PORTS
//  - clk      input   1      rising-edge clock; the only clock
//  - rst      input   1      asynchronous, active-high reset
//  - en       input   1      decode enable; 0 forces the idle output pattern
//  - data_in  input   IN_W   binary select index
//  - y_out    output  OUT_W  registered one-hot (or one-cold) decode result
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-high.
//  - Reset:
//    - rst=1 immediately (no clock edge needed) drives y_out to the idle pattern:
//      all 0 (ACTIVE_LOW=0) or all 1 (ACTIVE_LOW=1).
//    - Output is held while rst=1.
//    - Deassertion is sampled at the next rising clk; no glitch at deassertion.
//  - Latency: exactly 1 cycle.
//    - y_out after rising edge k reflects en/data_in sampled at edge k.
//    - No combinational path from inputs to y_out.
//  - Decode (ACTIVE_LOW=0):
//    - en=1: y_out[i] = (data_in == i) for every i.
//      - 00->0001, 01->0010, 10->0100, 11->1000.
//    - en=0: y_out = 0000, regardless of data_in.
//  - ACTIVE_LOW=1: y_out is the bitwise inverse of the ACTIVE_LOW=0 result.
//    - en=0 gives 1111.
//    - en=1, data_in=10 gives 1011.
//  - Invariants:
//    - en=1: exactly one bit asserted every cycle.
//    - en=0: zero bits asserted.
//  - X/Z on data_in while en=1: output is don't-care.
//    - The bench does not check this; RTL must not propagate X into the en=0 path.
//  - Simultaneous events:
//    - rst asserted in the same cycle as any input change: reset wins.
//    - en toggling every cycle: y_out alternates idle/decoded with 1-cycle lag.
//  - Changing data_in every cycle with en=1: y_out follows every cycle; no hold or hysteresis.
// STRUCTURE
//  - Package decoder_pkg:
//    - localparam DEC_IN_W=2, DEC_OUT_W=4
//    - function onehot_decode(sel) returning OUT_W bits
//  - Sub-module decoder_2to4_core: purely combinational (en, data_in) -> one-hot.
//  - Top: instantiates the core, applies ACTIVE_LOW inversion, adds the output register
//    with async reset.
//  - Elaboration-time check: IN_W outside 1..4 is a fatal error.
// TESTING
//  - Reset: assert rst mid-cycle with en=1, data_in=11 -> y_out=0000 immediately,
//    before the next clk edge; held while rst=1.
//  - Full sweep: en=1, data_in 00,01,10,11 on consecutive edges -> y_out 0001,0010,0100,1000,
//    each 1 cycle after its input.
//  - Disable: en=0, data_in=10 -> y_out=0000 next cycle; raise en=1 -> 0100 one cycle later.
//  - Random: 20+ cycles of $random data_in with en=1 -> scoreboard 1<<data_in (1-cycle delay);
//    $countones(y_out)==1 every cycle.
//  - Polarity: ACTIVE_LOW=1, en=1, data_in=01 -> 1101; en=0 -> 1111; reset -> 1111.
//  - Reset release: deassert rst between edges with en=1, data_in=01 -> y_out stays idle
//    until the next rising clk, then 0010.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants and the one-hot decode helper for the registered binary decoder.
// The helper works at the widest supported size; callers slice down to their width.

package decoder_pkg;

    localparam int unsigned DEC_IN_W      = 2;
    localparam int unsigned DEC_OUT_W     = 4;
    localparam int unsigned DEC_MAX_IN_W  = 4;
    localparam int unsigned DEC_MAX_OUT_W = 16;

    function automatic logic [DEC_MAX_OUT_W-1:0] onehot_decode(
        input logic [DEC_MAX_IN_W-1:0] sel
    );
        logic [DEC_MAX_OUT_W-1:0] dec;
        dec      = '0;
        dec[sel] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/decoder_2to4_core.sv
// Combinational binary-to-one-hot decode with enable masking.
// Masking with en keeps an unknown select from leaking into the disabled output.

module decoder_2to4_core
    import decoder_pkg::*;
#(
    parameter  int unsigned IN_W  = DEC_IN_W,
    localparam int unsigned OUT_W = 1 << IN_W
) (
    input  logic             en,
    input  logic [IN_W-1:0]  data_in,
    output logic [OUT_W-1:0] dec_out
);

    logic [DEC_MAX_IN_W-1:0]  sel_ext;
    logic [DEC_MAX_OUT_W-1:0] dec_full;

    always_comb begin
        sel_ext            = '0;
        sel_ext[IN_W-1:0]  = data_in;
        dec_full           = onehot_decode(sel_ext);
        dec_out            = dec_full[OUT_W-1:0] & {OUT_W{en}};
    end

    // Upper lines of the wide decode are never selected for narrower instances.
    if (OUT_W < DEC_MAX_OUT_W) begin : g_unused
        logic unused_dec_hi;
        assign unused_dec_hi = ^dec_full[DEC_MAX_OUT_W-1:OUT_W];
    end

endmodule

// File: rtl/decoder_2to4.sv
// Registered binary-to-one-hot (or one-cold) decoder with enable.
// One cycle of latency; asynchronous reset drives the idle pattern.

module decoder_2to4
    import decoder_pkg::*;
#(
    parameter  int unsigned IN_W       = DEC_IN_W,
    parameter  bit          ACTIVE_LOW = 1'b0,
    localparam int unsigned OUT_W      = 1 << IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  data_in,
    output logic [OUT_W-1:0] y_out
);

    if (IN_W < 1 || IN_W > DEC_MAX_IN_W) begin : g_bad_width
        $fatal(1, "decoder_2to4: IN_W=%0d outside supported range 1..%0d", IN_W, DEC_MAX_IN_W);
    end

    localparam logic [OUT_W-1:0] IdlePattern = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    logic [OUT_W-1:0] dec;
    logic [OUT_W-1:0] y_d;
    logic [OUT_W-1:0] y_q;

    decoder_2to4_core #(
        .IN_W (IN_W)
    ) u_core (
        .en      (en),
        .data_in (data_in),
        .dec_out (dec)
    );

    // Inverting the masked decode gives all-ones when disabled, matching the idle pattern.
    always_comb begin
        y_d = dec ^ {OUT_W{ACTIVE_LOW}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= IdlePattern;
        end else begin
            y_q <= y_d;
        end
    end

    assign y_out = y_q;

endmodule

// File: tb/tb_decoder_2to4.sv
// Directed and table-driven bench for decoder_2to4, covering both output polarities.
// Two instances share the stimulus; the active-low one must always be the inverse.

module tb_decoder_2to4;

    typedef struct {
        logic       en;
        logic [1:0] din;
        logic [3:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] data_in;
    logic [3:0] y_hi;
    logic [3:0] y_lo;

    int total;
    int bad;

    decoder_2to4 #(
        .IN_W       (2),
        .ACTIVE_LOW (1'b0)
    ) u_dut_hi (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .data_in (data_in),
        .y_out   (y_hi)
    );

    decoder_2to4 #(
        .IN_W       (2),
        .ACTIVE_LOW (1'b1)
    ) u_dut_lo (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .data_in (data_in),
        .y_out   (y_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Compare both polarities against one active-high expectation.
    task automatic check_both(input string name, input logic [3:0] exp);
        check4({name, "/hi"}, y_hi, exp);
        check4({name, "/lo"}, y_lo, ~exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        en      = 1'b0;
        data_in = 2'b00;

        vecs[0]  = '{en: 1'b1, din: 2'b00, exp: 4'b0001};
        vecs[1]  = '{en: 1'b1, din: 2'b01, exp: 4'b0010};
        vecs[2]  = '{en: 1'b1, din: 2'b10, exp: 4'b0100};
        vecs[3]  = '{en: 1'b1, din: 2'b11, exp: 4'b1000};
        vecs[4]  = '{en: 1'b0, din: 2'b10, exp: 4'b0000};
        vecs[5]  = '{en: 1'b1, din: 2'b10, exp: 4'b0100};
        vecs[6]  = '{en: 1'b0, din: 2'b10, exp: 4'b0000};
        vecs[7]  = '{en: 1'b1, din: 2'b11, exp: 4'b1000};
        vecs[8]  = '{en: 1'b0, din: 2'b11, exp: 4'b0000};
        vecs[9]  = '{en: 1'b1, din: 2'b00, exp: 4'b0001};
        vecs[10] = '{en: 1'b0, din: 2'b01, exp: 4'b0000};
        vecs[11] = '{en: 1'b1, din: 2'b01, exp: 4'b0010};

        // Reset takes effect with no clock edge.
        #2 rst = 1'b1;
        #1 check_both("reset_async", 4'b0000);
        step();
        check_both("reset_hold", 4'b0000);

        rst = 1'b0;
        step();
        check_both("idle_after_reset", 4'b0000);

        // Table: sweep, disable/enable, en toggling every cycle.
        foreach (vecs[i]) begin
            en      = vecs[i].en;
            data_in = vecs[i].din;
            step();
            check_both($sformatf("vec%0d", i), vecs[i].exp);
            check_int($sformatf("vec%0d_ones", i), $countones(y_hi), vecs[i].en ? 1 : 0);
        end

        // Latency: output must not move before the capturing edge.
        en      = 1'b1;
        data_in = 2'b11;
        #3 check_both("no_comb_path", 4'b0010);
        step();
        check_both("latency_one", 4'b1000);

        // Mid-cycle reset with active inputs clears immediately and holds.
        en      = 1'b1;
        data_in = 2'b00;
        step();
        check_both("pre_reset", 4'b0001);
        #3;
        data_in = 2'b11;
        rst     = 1'b1;
        #1 check_both("reset_midcycle", 4'b0000);
        step();
        check_both("reset_held_edge1", 4'b0000);
        step();
        check_both("reset_held_edge2", 4'b0000);

        // Release between edges: stays idle until the next rising edge.
        data_in = 2'b01;
        #3 rst = 1'b0;
        #1 check_both("release_idle", 4'b0000);
        step();
        check_both("release_first", 4'b0010);

        // Random selects with en held high.
        for (int k = 0; k < 24; k++) begin
            logic [1:0] r;
            r       = 2'($urandom_range(0, 3));
            data_in = r;
            step();
            check_both($sformatf("rand%0d", k), 4'b0001 << r);
            check_int($sformatf("rand%0d_ones", k), $countones(y_hi), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
